axi_burst_arbiter: RTL and testbench
====================================

// Module: axi_burst_arbiter
// PURPOSE
//  Shares the single AXI master port of the external DDR controller among 4 frame channels (each with write + read side).
//  Takes burst requests (addr, len) from the per-channel frame FIFOs and picks one by round robin.
//  Drives the AW/AR address phase for that burst and outputs a select index so the W/R data mux feeds the owning channel.
//  Holds the grant until the burst completes. Only one burst is outstanding at any time.
// PARAMETERS
//  ADDR_BITS  32  width of burst start address (byte address)
//  CH_NUM     4   channels per direction; fixed at 4 for this revision
// PORTS
//  ACLK           in   1     single clock, all logic rising-edge
//  ARESET         in   1     synchronous, active-high reset
//  wr_req         in   4     per-channel write burst request, level; held until wr_ack
//  wr_addr        in   4*32  per-channel write start address, ch n at [32n+31:32n], stable while wr_req
//  wr_len         in   4*8   per-channel AWLEN (beats-1), ch n at [8n+7:8n]
//  wr_ack         out  4     1-cycle pulse on the AW handshake of that channel's burst
//  wr_done        out  4     1-cycle pulse on the B handshake of that channel's burst
//  rd_req         in   4     per-channel read burst request, level; held until rd_ack
//  rd_addr        in   4*32  per-channel read start address
//  rd_len         in   4*8   per-channel ARLEN
//  rd_ack         out  4     1-cycle pulse on the AR handshake
//  rd_done        out  4     1-cycle pulse on the R beat with RLAST (RVALID&RREADY&RLAST)
//  sel_ch         out  2     channel index owning the bus
//  sel_wr         out  1     1 = write burst granted, 0 = read burst granted
//  sel_valid      out  1     grant active (WR_ADDR..RD_WAIT); the data mux is gated by this
//  M_AXI_AWADDR   out  32    registered; M_AXI_AWLEN out 8; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
//  M_AXI_BVALID   in   1;    M_AXI_BREADY out 1
//  M_AXI_ARADDR   out  32;   M_AXI_ARLEN out 8; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
//  M_AXI_RVALID   in   1;    M_AXI_RREADY in 1 (observed only); M_AXI_RLAST in 1
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0; all outputs 0 (AxVALID, BREADY, acks, dones, sel_*).
//  Request vector req[7:0] = {rd_req, wr_req}; bits 0-3 are wr ch0-3, bits 4-7 are rd ch0-3.
//  Round robin: winner = first set bit of req searched from rr_ptr+1 upward, wrapping 7->0.
//    On grant, rr_ptr <= winner. Exactly one winner; no request is starved (max wait 7 bursts).
//  FSM:
//   IDLE    : if |req -> latch winner, addr, len into sel_ch/sel_wr/addr/len regs; next WR_ADDR or RD_ADDR.
//             Decision uses req sampled this cycle, so AxVALID rises 1 cycle after req is seen.
//   WR_ADDR : AWVALID=1, AWADDR/AWLEN from regs, stable until AWREADY.
//             On AWVALID&AWREADY: wr_ack[ch] pulse, AWVALID<=0, next WR_WAIT.
//   WR_WAIT : BREADY=1; on BVALID: wr_done[ch] pulse, BREADY<=0, next IDLE. BRESP ignored.
//   RD_ADDR : same as WR_ADDR on the AR channel; rd_ack pulse; next RD_WAIT.
//   RD_WAIT : on RVALID&RREADY&RLAST: rd_done[ch] pulse, next IDLE.
//  sel_valid=1 in WR_ADDR/WR_WAIT/RD_ADDR/RD_WAIT; sel_ch/sel_wr hold for the whole grant.
//  A request deasserted after the winner is latched is ignored; the granted burst still completes.
//  Simultaneous wr and rd of the same channel are separate requesters; RR decides.
//  A B or RLAST arriving in an unexpected state (e.g. BVALID in RD_WAIT) is ignored.
//  ARESET mid-burst: FSM -> IDLE next edge, all valids drop. The DDR side must also be reset.
//  Minimum spacing between grants: IDLE costs 1 cycle after each done.
// CONFIGURATION
//  RD_PRIORITY_EN defined: if any rd_req is set in IDLE, RR search is over bits 4-7 only (reads starve writes).
//    Use this when display underrun is worse than write drop.
//  Not defined: flat 8-way RR as above.
// TESTING
//  1 single wr_req[2], addr 0x1000, len 15, AWREADY=1 -> AWVALID 1 cycle after req,
//    wr_ack[2] on the handshake, sel_ch=2 sel_wr=1; BVALID 3 cycles later -> wr_done[2], back to IDLE.
//  2 all 8 req held high, rr_ptr=0 -> grant order wr1,wr2,wr3,rd0,rd1,rd2,rd3,wr0, repeating.
//  3 AWREADY low for 10 cycles -> AWVALID/AWADDR stable for those 10 cycles, no ack until AWREADY.
//  4 rd_req[1], len 3, RLAST on beat 4 with RVALID gaps -> rd_done[1] only on the RLAST beat; non-last beats produce no done.
//  5 ARESET asserted in WR_WAIT -> next cycle all outputs 0, state IDLE; pending req re-granted after release.
//  6 RD_PRIORITY_EN, wr_req=4'hF and rd_req[3] set -> rd3 granted first; writes are granted only when no rd_req is set.

Source files
------------

// File: rtl/axi_burst_arbiter.sv
// axi_burst_arbiter: shares one AXI master port of the DDR controller among
// 4 write and 4 read frame channels. A round-robin choice over the 8 requesters
// picks one burst at a time. The arbiter drives the AW or AR address phase for
// that burst and holds the grant until the B response or the RLAST beat. Only
// one burst is outstanding at any time.
//
// Optional feature macro: RD_PRIORITY_EN. When it is defined, any pending read
// request masks all writes from the round-robin search.
//
// Ports:
//   ACLK, ARESET             clock and synchronous active-high reset
//   wr_req/wr_addr/wr_len    per-channel write burst requests (ch n at slice n)
//   wr_ack/wr_done           1-cycle pulses on the AW handshake and on the B handshake
//   rd_req/rd_addr/rd_len    per-channel read burst requests
//   rd_ack/rd_done           1-cycle pulses on the AR handshake and on the RLAST beat
//   sel_ch/sel_wr/sel_valid  owner of the bus, used to steer the W/R data mux
//   M_AXI_*                  AXI address, B and R handshake signals (data paths not routed here)
module axi_burst_arbiter #(
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [3:0]             wr_req,
    input  logic [4*ADDR_BITS-1:0] wr_addr,
    input  logic [31:0]            wr_len,
    output logic [3:0]             wr_ack,
    output logic [3:0]             wr_done,
    input  logic [3:0]             rd_req,
    input  logic [4*ADDR_BITS-1:0] rd_addr,
    input  logic [31:0]            rd_len,
    output logic [3:0]             rd_ack,
    output logic [3:0]             rd_done,
    output logic [1:0]             sel_ch,
    output logic                   sel_wr,
    output logic                   sel_valid,
    output logic [ADDR_BITS-1:0]   M_AXI_AWADDR,
    output logic [7:0]             M_AXI_AWLEN,
    output logic                   M_AXI_AWVALID,
    input  logic                   M_AXI_AWREADY,
    input  logic                   M_AXI_BVALID,
    output logic                   M_AXI_BREADY,
    output logic [ADDR_BITS-1:0]   M_AXI_ARADDR,
    output logic [7:0]             M_AXI_ARLEN,
    output logic                   M_AXI_ARVALID,
    input  logic                   M_AXI_ARREADY,
    input  logic                   M_AXI_RVALID,
    input  logic                   M_AXI_RREADY,
    input  logic                   M_AXI_RLAST
);

    localparam int unsigned CH_NUM  = 4;
    localparam int unsigned REQ_NUM = 2 * CH_NUM;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned LEN_W   = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_WAIT = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;

    logic [REQ_NUM-1:0]     req_c;
    logic [REQ_NUM-1:0]     cand_c;
    logic [IDX_W-1:0]       idx_c;
    logic [IDX_W-1:0]       win_c;
    logic                   win_valid_c;
    logic [ADDR_BITS-1:0]   addr_c;
    logic [LEN_W-1:0]       len_c;

    // Bits 0-3 are write channels 0-3; bits 4-7 are read channels 0-3.
    assign req_c = {rd_req, wr_req};

`ifdef RD_PRIORITY_EN
    // Any pending read removes all writes from the search.
    assign cand_c = (|rd_req) ? {rd_req, 4'b0000} : req_c;
`else
    assign cand_c = req_c;
`endif

    // Search starts at rr_ptr+1 and wraps 7->0. The last step (i=REQ_NUM) revisits rr_ptr.
    always_comb begin
        win_c       = '0;
        win_valid_c = 1'b0;
        idx_c       = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            idx_c = rr_ptr + IDX_W'(i);
            if (!win_valid_c && cand_c[idx_c]) begin
                win_c       = idx_c;
                win_valid_c = 1'b1;
            end
        end
    end

    // Burst parameters of the winning requester
    always_comb begin
        addr_c = wr_addr[ADDR_BITS*win_c[1:0] +: ADDR_BITS];
        len_c  = wr_len[LEN_W*win_c[1:0] +: LEN_W];
        if (win_c[2]) begin
            addr_c = rd_addr[ADDR_BITS*win_c[1:0] +: ADDR_BITS];
            len_c  = rd_len[LEN_W*win_c[1:0] +: LEN_W];
        end
    end

    // Grant FSM; all outputs are registered
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            wr_ack        <= '0;
            wr_done       <= '0;
            rd_ack        <= '0;
            rd_done       <= '0;
            sel_ch        <= '0;
            sel_wr        <= 1'b0;
            sel_valid     <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
            M_AXI_ARVALID <= 1'b0;
        end else begin
            wr_ack  <= '0;
            wr_done <= '0;
            rd_ack  <= '0;
            rd_done <= '0;
            case (state)
                IDLE: begin
                    if (win_valid_c) begin
                        rr_ptr    <= win_c;
                        sel_ch    <= win_c[1:0];
                        sel_wr    <= ~win_c[2];
                        sel_valid <= 1'b1;
                        if (win_c[2]) begin
                            M_AXI_ARADDR  <= addr_c;
                            M_AXI_ARLEN   <= len_c;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_ADDR;
                        end else begin
                            M_AXI_AWADDR  <= addr_c;
                            M_AXI_AWLEN   <= len_c;
                            M_AXI_AWVALID <= 1'b1;
                            state         <= WR_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        wr_ack[sel_ch] <= 1'b1;
                        M_AXI_AWVALID  <= 1'b0;
                        M_AXI_BREADY   <= 1'b1;
                        state          <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (M_AXI_BVALID) begin
                        wr_done[sel_ch] <= 1'b1;
                        M_AXI_BREADY    <= 1'b0;
                        sel_valid       <= 1'b0;
                        state           <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        rd_ack[sel_ch] <= 1'b1;
                        M_AXI_ARVALID  <= 1'b0;
                        state          <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Only the last beat of the granted read ends the grant
                    if (M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST) begin
                        rd_done[sel_ch] <= 1'b1;
                        sel_valid       <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Testbench for axi_burst_arbiter: directed scenarios plus randomized traffic
// checked against a requester-level round-robin model.
module tb_axi_burst_arbiter;

    localparam int unsigned AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      wr_req, rd_req;
    logic [4*AW-1:0] wr_addr, rd_addr;
    logic [31:0]     wr_len, rd_len;
    logic [3:0]      wr_ack, wr_done, rd_ack, rd_done;
    logic [1:0]      sel_ch;
    logic            sel_wr, sel_valid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic            awvalid, awready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, rlast;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pending requests, their bursts, and the last granted requester
    logic [7:0]  m_req;
    logic [31:0] m_addr [8];
    logic [7:0]  m_len  [8];
    int          m_ptr;

    logic [102:0] all_outs;
    assign all_outs = {wr_ack, wr_done, rd_ack, rd_done, sel_ch, sel_wr, sel_valid,
                       awaddr, awlen, awvalid, bready, araddr, arlen, arvalid};

    always #5 clk = ~clk;

    axi_burst_arbiter #(.ADDR_BITS(AW)) dut (
        .ACLK(clk), .ARESET(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
        .sel_ch(sel_ch), .sel_wr(sel_wr), .sel_valid(sel_valid),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RLAST(rlast)
    );

    // Round-robin rule: first pending requester after the last winner, wrapping 7->0
    function automatic int exp_winner(input logic [7:0] r, input int ptr);
        logic [7:0] cand;
        cand = r;
`ifdef RD_PRIORITY_EN
        if (r[7:4] != 4'h0) cand = {r[7:4], 4'h0};
`endif
        for (int i = 1; i <= 8; i++) begin
            if (cand[(ptr + i) % 8]) return (ptr + i) % 8;
        end
        return -1;
    endfunction

    task automatic apply_reqs();
        for (int k = 0; k < 4; k++) begin
            wr_req[k]          = m_req[k];
            rd_req[k]          = m_req[k+4];
            wr_addr[k*32 +: 32] = m_addr[k];
            rd_addr[k*32 +: 32] = m_addr[k+4];
            wr_len[k*8 +: 8]    = m_len[k];
            rd_len[k*8 +: 8]    = m_len[k+4];
        end
    endtask

    task automatic idle_inputs();
        awready = 1'b0; arready = 1'b0; bvalid = 1'b0;
        rvalid  = 1'b0; rready  = 1'b0; rlast  = 1'b0;
        m_req = '0;
        for (int k = 0; k < 8; k++) begin
            m_addr[k] = '0;
            m_len[k]  = '0;
        end
        apply_reqs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    // Stimulus only: accept the address phase, retire the requester, finish a 1-beat burst
    task automatic drive_complete(input int w);
        if (w < 4) awready = 1'b1; else arready = 1'b1;
        @(negedge clk);
        awready = 1'b0; arready = 1'b0;
        m_req[w] = 1'b0;
        apply_reqs();
        if (w < 4) bvalid = 1'b1;
        else begin rvalid = 1'b1; rlast = 1'b1; rready = 1'b1; end
        @(negedge clk);
        bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
        m_req = 8'hFF;
        apply_reqs();
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL reset_with_req: got %h expected 0", all_outs); end
        m_req = '0;
        apply_reqs();
        rst   = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL idle_no_req: got %h expected 0", all_outs); end
    endtask

    task automatic test_single_write();
        do_reset();
        m_req[2] = 1'b1; m_addr[2] = 32'h1000; m_len[2] = 8'd15;
        apply_reqs();
        awready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({awvalid, awaddr, awlen, arvalid} !== {1'b1, 32'h1000, 8'd15, 1'b0}) begin
            n_fail++; $display("FAIL sw_aw: got v=%b a=%h l=%0d arv=%b", awvalid, awaddr, awlen, arvalid);
        end
        n_tests++;
        if ({sel_valid, sel_wr, sel_ch, wr_ack} !== {1'b1, 1'b1, 2'd2, 4'h0}) begin
            n_fail++; $display("FAIL sw_sel: got v=%b wr=%b ch=%0d ack=%b expected 1 1 2 0000", sel_valid, sel_wr, sel_ch, wr_ack);
        end
        @(negedge clk);
        awready = 1'b0;
        n_tests++;
        if ({wr_ack, awvalid, bready} !== {4'b0100, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL sw_ack: got ack=%b awv=%b brdy=%b expected 0100 0 1", wr_ack, awvalid, bready);
        end
        m_req[2] = 1'b0;
        apply_reqs();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({wr_ack, wr_done, bready, sel_valid, sel_ch} !== {4'h0, 4'h0, 1'b1, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL sw_wait: got ack=%b done=%b brdy=%b sv=%b ch=%0d", wr_ack, wr_done, bready, sel_valid, sel_ch);
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        n_tests++;
        if ({wr_done, bready, sel_valid} !== {4'b0100, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL sw_done: got done=%b brdy=%b sv=%b expected 0100 0 0", wr_done, bready, sel_valid);
        end
        @(negedge clk);
        n_tests++;
        if ({wr_done, sel_valid, awvalid, arvalid} !== 7'h0) begin
            n_fail++; $display("FAIL sw_idle: got done=%b sv=%b awv=%b arv=%b expected all 0", wr_done, sel_valid, awvalid, arvalid);
        end
    endtask

    task automatic test_round_robin();
        int order [8];
        int e;
`ifdef RD_PRIORITY_EN
        order = '{4, 5, 6, 7, 4, 5, 6, 7};
`else
        order = '{1, 2, 3, 4, 5, 6, 7, 0};
`endif
        do_reset();
        for (int k = 0; k < 8; k++) begin
            m_req[k]  = 1'b1;
            m_addr[k] = 32'h100 * (k + 1);
        end
        apply_reqs();
        for (int g = 0; g < 16; g++) begin
            e = order[g % 8];
            @(negedge clk);
            n_tests++;
            if ({sel_valid, sel_wr, sel_ch} !== {1'b1, 1'(e < 4), 2'(e % 4)}) begin
                n_fail++; $display("FAIL rr_order[%0d]: got wr=%b ch=%0d v=%b expected wr=%b ch=%0d", g, sel_wr, sel_ch, sel_valid, e < 4, e % 4);
            end
            n_tests++;
            if ((e < 4) ? (awaddr !== 32'h100 * (e + 1)) : (araddr !== 32'h100 * (e + 1))) begin
                n_fail++; $display("FAIL rr_addr[%0d]: got aw=%h ar=%h expected %h", g, awaddr, araddr, 32'h100 * (e + 1));
            end
            if (e < 4) awready = 1'b1; else arready = 1'b1;
            @(negedge clk);
            awready = 1'b0; arready = 1'b0;
            if (e < 4) bvalid = 1'b1;
            else begin rvalid = 1'b1; rlast = 1'b1; rready = 1'b1; end
            @(negedge clk);
            bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_aw_stall();
        do_reset();
        m_req[0] = 1'b1; m_addr[0] = 32'h2000; m_len[0] = 8'd7;
        apply_reqs();
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({awvalid, awaddr, awlen, wr_ack} !== {1'b1, 32'h2000, 8'd7, 4'h0}) begin
                n_fail++; $display("FAIL stall[%0d]: got v=%b a=%h l=%0d ack=%b", i, awvalid, awaddr, awlen, wr_ack);
            end
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        n_tests++;
        if ({wr_ack, awvalid} !== {4'b0001, 1'b0}) begin
            n_fail++; $display("FAIL stall_ack: got ack=%b awv=%b expected 0001 0", wr_ack, awvalid);
        end
        m_req[0] = 1'b0;
        apply_reqs();
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        n_tests++;
        if (wr_done !== 4'b0001) begin n_fail++; $display("FAIL stall_done: got %b expected 0001", wr_done); end
    endtask

    task automatic test_read_gaps();
        logic [6:0] vpat;
        int         beat;
        vpat = 7'b1100101;
        do_reset();
        m_req[5] = 1'b1; m_addr[5] = 32'h8000; m_len[5] = 8'd3;
        apply_reqs();
        arready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({arvalid, araddr, arlen, sel_ch, sel_wr, awvalid} !== {1'b1, 32'h8000, 8'd3, 2'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rd_ar: got v=%b a=%h l=%0d ch=%0d wr=%b awv=%b", arvalid, araddr, arlen, sel_ch, sel_wr, awvalid);
        end
        @(negedge clk);
        arready = 1'b0;
        n_tests++;
        if ({rd_ack, arvalid} !== {4'b0010, 1'b0}) begin
            n_fail++; $display("FAIL rd_ack: got ack=%b arv=%b expected 0010 0", rd_ack, arvalid);
        end
        m_req[5] = 1'b0;
        apply_reqs();
        rready = 1'b1;
        beat   = 0;
        for (int c = 0; c < 7; c++) begin
            rvalid = vpat[c];
            // RLAST on a gap cycle (c=3) has no RVALID and must be ignored
            rlast  = (vpat[c] && beat == 3) || (c == 3);
            @(negedge clk);
            if (vpat[c]) beat++;
            n_tests++;
            if (rd_done !== ((c == 6) ? 4'b0010 : 4'b0000)) begin
                n_fail++; $display("FAIL rd_beat[%0d]: got done=%b expected %b", c, rd_done, (c == 6) ? 4'b0010 : 4'b0000);
            end
        end
        rvalid = 1'b0; rlast = 1'b0; rready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rd_done, sel_valid} !== 5'h0) begin
            n_fail++; $display("FAIL rd_after: got done=%b sv=%b expected 0", rd_done, sel_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_req[3] = 1'b1; m_addr[3] = 32'h3000;
        m_req[4] = 1'b1; m_addr[4] = 32'h4000;
        apply_reqs();
        awready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({awvalid, sel_ch, sel_wr} !== {1'b1, 2'd3, 1'b1}) begin
            n_fail++; $display("FAIL rm_grant: got awv=%b ch=%0d wr=%b expected 1 3 1", awvalid, sel_ch, sel_wr);
        end
        @(negedge clk);
        awready  = 1'b0;
        m_req[3] = 1'b0;
        apply_reqs();
        n_tests++;
        if ({wr_ack, bready} !== {4'b1000, 1'b1}) begin
            n_fail++; $display("FAIL rm_wait: got ack=%b brdy=%b expected 1000 1", wr_ack, bready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL rm_reset: got %h expected 0", all_outs); end
        rst   = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        n_tests++;
        if ({arvalid, araddr, sel_ch, sel_wr, sel_valid} !== {1'b1, 32'h4000, 2'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rm_regrant: got arv=%b a=%h ch=%0d wr=%b sv=%b", arvalid, araddr, sel_ch, sel_wr, sel_valid);
        end
        drive_complete(4);
        n_tests++;
        if (rd_done !== 4'b0001) begin n_fail++; $display("FAIL rm_done: got %b expected 0001", rd_done); end
    endtask

    task automatic test_rd_priority();
        int first, second;
`ifdef RD_PRIORITY_EN
        first = 7; second = 0;
`else
        first = 1; second = 2;
`endif
        do_reset();
        m_req = 8'b1000_1111;
        apply_reqs();
        @(negedge clk);
        n_tests++;
        if ({sel_valid, sel_wr, sel_ch} !== {1'b1, 1'(first < 4), 2'(first % 4)}) begin
            n_fail++; $display("FAIL prio_first: got wr=%b ch=%0d expected wr=%b ch=%0d", sel_wr, sel_ch, first < 4, first % 4);
        end
        drive_complete(first);
        @(negedge clk);
        n_tests++;
        if ({sel_valid, sel_wr, sel_ch} !== {1'b1, 1'(second < 4), 2'(second % 4)}) begin
            n_fail++; $display("FAIL prio_second: got wr=%b ch=%0d expected wr=%b ch=%0d", sel_wr, sel_ch, second < 4, second % 4);
        end
        drive_complete(second);
    endtask

    task automatic test_random_traffic(input int n_bursts);
        int   w, d, beats, cnt, guard, k;
        logic hs, last;
        do_reset();
        for (int b = 0; b < n_bursts; b++) begin
            for (int j = 0; j < 8; j++) begin
                if (!m_req[j] && $urandom_range(0, 2) == 0) begin
                    m_req[j]  = 1'b1;
                    m_addr[j] = $urandom;
                    m_len[j]  = 8'($urandom_range(0, 5));
                end
            end
            if (m_req == '0) begin
                k = $urandom_range(0, 7);
                m_req[k]  = 1'b1;
                m_addr[k] = $urandom;
                m_len[k]  = 8'($urandom_range(0, 5));
            end
            apply_reqs();
            w = exp_winner(m_req, m_ptr);
            @(negedge clk);
            n_tests++;
            if ({sel_valid, sel_wr, sel_ch, awvalid, arvalid} !== {1'b1, 1'(w < 4), 2'(w % 4), 1'(w < 4), 1'(w >= 4)}) begin
                n_fail++; $display("FAIL rnd_grant[%0d]: got sv=%b wr=%b ch=%0d awv=%b arv=%b expected requester %0d", b, sel_valid, sel_wr, sel_ch, awvalid, arvalid, w);
            end
            n_tests++;
            if ((w < 4) ? ({awaddr, awlen} !== {m_addr[w], m_len[w]}) : ({araddr, arlen} !== {m_addr[w], m_len[w]})) begin
                n_fail++; $display("FAIL rnd_addr[%0d]: got aw=%h/%0d ar=%h/%0d expected %h/%0d", b, awaddr, awlen, araddr, arlen, m_addr[w], m_len[w]);
            end
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                n_tests++;
                if ({awvalid, arvalid, wr_ack, rd_ack} !== {1'(w < 4), 1'(w >= 4), 8'h0}) begin
                    n_fail++; $display("FAIL rnd_hold[%0d]: got awv=%b arv=%b ack=%b%b", b, awvalid, arvalid, rd_ack, wr_ack);
                end
            end
            if (w < 4) awready = 1'b1; else arready = 1'b1;
            @(negedge clk);
            awready = 1'b0; arready = 1'b0;
            n_tests++;
            if ({rd_ack, wr_ack, awvalid, arvalid} !== {8'(1 << w), 2'b00}) begin
                n_fail++; $display("FAIL rnd_ack[%0d]: got ack=%b%b awv=%b arv=%b expected %b", b, rd_ack, wr_ack, awvalid, arvalid, 8'(1 << w));
            end
            m_req[w] = 1'b0;
            apply_reqs();
            m_ptr = w;
            if (w < 4) begin
                d = $urandom_range(0, 4);
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    n_tests++;
                    if ({bready, wr_done, rd_done, sel_valid} !== {1'b1, 8'h0, 1'b1}) begin
                        n_fail++; $display("FAIL rnd_bwait[%0d]: got brdy=%b done=%b%b sv=%b", b, bready, rd_done, wr_done, sel_valid);
                    end
                end
                bvalid = 1'b1;
                @(negedge clk);
                bvalid = 1'b0;
                n_tests++;
                if ({wr_done, rd_done, bready, sel_valid} !== {4'(1 << w), 4'h0, 2'b00}) begin
                    n_fail++; $display("FAIL rnd_wdone[%0d]: got done=%b%b brdy=%b sv=%b", b, rd_done, wr_done, bready, sel_valid);
                end
            end else begin
                beats = int'(m_len[w]) + 1;
                cnt   = 0;
                guard = 0;
                while (cnt < beats && guard < 200) begin
                    rvalid = 1'($urandom_range(0, 1));
                    rready = ($urandom_range(0, 3) != 0);
                    rlast  = (cnt == beats - 1);
                    bvalid = ($urandom_range(0, 4) == 0);
                    hs     = rvalid & rready;
                    last   = hs && (cnt == beats - 1);
                    @(negedge clk);
                    guard++;
                    if (hs) cnt++;
                    n_tests++;
                    if ({rd_done, wr_done, sel_valid} !== {(last ? 4'(1 << (w - 4)) : 4'h0), 4'h0, !last}) begin
                        n_fail++; $display("FAIL rnd_rbeat[%0d]: got done=%b%b sv=%b last=%b", b, rd_done, wr_done, sel_valid, last);
                    end
                end
                rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; bvalid = 1'b0;
                if (cnt < beats) begin
                    n_tests++; n_fail++;
                    $display("FAIL rnd_timeout[%0d]: got %0d beats expected %0d", b, cnt, beats);
                end
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        m_ptr = 0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_aw_stall();
        test_read_gaps();
        test_reset_mid();
        test_rd_priority();
        test_random_traffic(150);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
